data_mem_ctrl: RTL and testbench

Data-memory controller sitting directly downstream of the RV32I CPU's load/store port. It takes the CPU's memory request (address, store data, read/write enables, access size), performs it against a word-wide synchronous RAM, and returns little-endian, sign- or zero-extended load data. Sub-word stores are done as read-modify-write. A stall output freezes the CPU's PC and register write until the access completes.

---
 rtl/data_mem_ctrl.sv | 152 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory controller between the RV32I load/store port and a word-wide synchronous RAM.
// Performs word accesses directly, sub-word stores by read-modify-write, and extends load data.
module data_mem_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ReadEn,
  input  logic              WriteEn,
  input  logic [31:0]       MemAddr,
  input  logic [31:0]       toMem,
  input  logic [1:0]        addMemControl,
  input  logic              loadUnsigned,
  output logic [31:0]       fromMem,
  output logic              stall,
  output logic              misalign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RMW_WAIT,
    DONE
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_t      state, state_nxt;
  logic [31:0] data_q;
  logic        misalign_q;

  logic        request;
  logic        illegal;
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_val;
  logic [31:0] merged;

  // Upper address bits are deliberately dropped so addresses alias modulo the RAM size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^MemAddr[31:ADDR_W+2];

  assign request  = ReadEn | WriteEn;
  assign mem_addr = MemAddr[ADDR_W+1:2];
  assign byte_sh  = {MemAddr[1:0], 3'b000};
  assign half_sh  = {MemAddr[1], 4'b0000};

  assign illegal = (addMemControl == 2'b11)
                 | ((addMemControl == SIZE_HALF) & MemAddr[0])
                 | ((addMemControl == SIZE_WORD) & (MemAddr[1:0] != 2'b00));

  // Little-endian lane extraction with sign/zero extension; word loads pass through.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    load_byte = mem_rdata[byte_sh +: 8];
    load_half = mem_rdata[half_sh +: 16];
    load_val  = mem_rdata;
    case (addMemControl)
      SIZE_BYTE: load_val = loadUnsigned ? {24'b0, load_byte} : {{24{load_byte[7]}}, load_byte};
      SIZE_HALF: load_val = loadUnsigned ? {16'b0, load_half} : {{16{load_half[15]}}, load_half};
      default:   load_val = mem_rdata;
    endcase
  end

  // Read-modify-write merge: replace only the addressed lane of the fetched word.
  always_comb begin
    merged = mem_rdata;
    if (addMemControl == SIZE_BYTE) begin
      merged[byte_sh +: 8] = toMem[7:0];
    end else begin
      merged[half_sh +: 16] = toMem[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      data_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (request) begin
            data_q     <= '0;
            misalign_q <= illegal;
          end
        end
        RD_WAIT: data_q     <= load_val;
        DONE:    misalign_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    fromMem   = '0;
    misalign  = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          stall = 1'b1;
          if (illegal) begin
            state_nxt = DONE;
          end else if (WriteEn && addMemControl == SIZE_WORD) begin
            mem_we    = 1'b1;
            mem_wdata = toMem;
            state_nxt = DONE;
          end else if (WriteEn) begin
            mem_re    = 1'b1;
            state_nxt = RMW_WAIT;
          end else begin
            mem_re    = 1'b1;
            state_nxt = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        stall     = 1'b1;
        state_nxt = DONE;
      end
      RMW_WAIT: begin
        stall     = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = merged;
        state_nxt = DONE;
      end
      DONE: begin
        fromMem   = data_q;
        misalign  = misalign_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a behavioural synchronous RAM behind it.
// Each test task drives accesses and compares latency, RAM traffic and load results.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ReadEn, WriteEn, loadUnsigned;
  logic [31:0] MemAddr, toMem;
  logic [1:0]  addMemControl;
  logic [31:0] fromMem;
  logic        stall, misalign;
  logic [9:0]  mem_addr;
  logic        mem_re, mem_we;
  logic [31:0] mem_rdata, mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          cyc;
    int          nre;
    int          nwe;
    logic [9:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        mis;
    logic        leak;
    logic        clash;
  } res_t;

  data_mem_ctrl #(.ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .ReadEn(ReadEn), .WriteEn(WriteEn), .MemAddr(MemAddr),
    .toMem(toMem), .addMemControl(addMemControl), .loadUnsigned(loadUnsigned),
    .fromMem(fromMem), .stall(stall), .misalign(misalign), .mem_addr(mem_addr),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic drive(input logic re, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [1:0] sz, input logic uns);
    ReadEn = re; WriteEn = we; MemAddr = addr; toMem = wd; addMemControl = sz; loadUnsigned = uns;
  endtask

  // Observes from just after a negedge until the DONE cycle (first cycle with stall low).
  task automatic watch(output res_t r);
    bit done = 0;
    r.cyc = 0; r.nre = 0; r.nwe = 0; r.waddr = '0; r.wdata = '0;
    r.rd = '0; r.mis = 1'b0; r.leak = 1'b0; r.clash = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      #1;
      r.cyc++;
      if (mem_re) r.nre++;
      if (mem_we) begin r.nwe++; r.waddr = mem_addr; r.wdata = mem_wdata; end
      if (mem_re && mem_we) r.clash = 1'b1;
      if (stall !== 1'b0) begin
        if (fromMem !== 32'h0 || misalign !== 1'b0) r.leak = 1'b1;
        @(negedge clk);
      end else begin
        r.rd = fromMem; r.mis = misalign; done = 1;
      end
    end
    if (!done) r.cyc = 99;
  endtask

  task automatic access(input logic re, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                        output res_t r);
    @(negedge clk);
    drive(re, we, addr, wd, sz, uns);
    watch(r);
  endtask

  task automatic idle();
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
  endtask

  task automatic test_reset();
    res_t r;
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    #2;
    n_cmp++; if ({stall, misalign, mem_re, mem_we, fromMem} !== 36'h0) begin
      n_bad++; $display("FAIL reset_outputs: got %h expected 0", {stall, misalign, mem_re, mem_we, fromMem});
    end
    ReadEn = 1'b1; #1;
    n_cmp++; if ({stall, mem_we} !== 2'b10) begin
      n_bad++; $display("FAIL reset_stall_follows_req: got %b expected 10", {stall, mem_we});
    end
    ReadEn = 1'b0;
    @(negedge clk); reset = 1'b0;
    access(1'b0, 1'b1, 32'h0, 32'h0BADF00D, 2'b10, 1'b0, r);
    n_cmp++; if (r.cyc !== 2 || r.nwe !== 1) begin
      n_bad++; $display("FAIL reset_setup_sw: got cyc=%0d we=%0d expected cyc=2 we=1", r.cyc, r.nwe);
    end
    idle();
    // LW to 0x1000 aliases word 0; reset lands in RD_WAIT.
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h1000, 32'h0, 2'b10, 1'b0);
    @(negedge clk); #1;
    n_cmp++; if ({stall, mem_re} !== 2'b10) begin
      n_bad++; $display("FAIL reset_in_rd_wait: got %b expected 10", {stall, mem_re});
    end
    reset = 1'b1; #1;
    n_cmp++; if ({stall, mem_we, misalign, fromMem} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL reset_mid_access: got %h expected %h",
                        {stall, mem_we, misalign, fromMem}, {1'b1, 1'b0, 1'b0, 32'h0});
    end
    @(negedge clk); reset = 1'b0;
    watch(r);
    n_cmp++; if (r.cyc !== 3 || r.rd !== 32'h0BADF00D || r.nwe !== 0 || r.leak) begin
      n_bad++; $display("FAIL reset_restart_lw: got cyc=%0d rd=%h we=%0d expected cyc=3 rd=0badf00d we=0",
                        r.cyc, r.rd, r.nwe);
    end
    idle();
  endtask

  task automatic test_word();
    res_t r;
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, r);
    n_cmp++; if (r.cyc !== 2 || r.nwe !== 1 || r.nre !== 0 || r.waddr !== 10'd4 || r.wdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL sw_word: got cyc=%0d re=%0d we=%0d addr=%0d data=%h expected cyc=2 re=0 we=1 addr=4 data=deadbeef",
                        r.cyc, r.nre, r.nwe, r.waddr, r.wdata);
    end
    idle();
    access(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, r);
    n_cmp++; if (r.cyc !== 3 || r.rd !== 32'hDEADBEEF || r.nwe !== 0 || r.nre !== 1 || r.leak) begin
      n_bad++; $display("FAIL lw_word: got cyc=%0d rd=%h we=%0d expected cyc=3 rd=deadbeef we=0", r.cyc, r.rd, r.nwe);
    end
    idle();
  endtask

  task automatic test_byte();
    res_t r;
    access(1'b0, 1'b1, 32'h11, 32'h000000AA, 2'b00, 1'b0, r);
    n_cmp++; if (r.cyc !== 3 || r.nre !== 1 || r.nwe !== 1 || r.waddr !== 10'd4 || r.wdata !== 32'hDEADAAEF || r.clash) begin
      n_bad++; $display("FAIL sb_rmw: got cyc=%0d re=%0d we=%0d data=%h expected cyc=3 re=1 we=1 data=deadaaef",
                        r.cyc, r.nre, r.nwe, r.wdata);
    end
    idle();
    access(1'b1, 1'b0, 32'h11, 32'h0, 2'b00, 1'b0, r);
    n_cmp++; if (r.rd !== 32'hFFFFFFAA) begin
      n_bad++; $display("FAIL lb_signed: got %h expected ffffffaa", r.rd);
    end
    idle();
    access(1'b1, 1'b0, 32'h11, 32'h0, 2'b00, 1'b1, r);
    n_cmp++; if (r.rd !== 32'h000000AA) begin
      n_bad++; $display("FAIL lbu: got %h expected 000000aa", r.rd);
    end
    idle();
  endtask

  task automatic test_half();
    res_t r;
    access(1'b0, 1'b1, 32'h10, 32'h11223344, 2'b10, 1'b0, r);
    idle();
    access(1'b0, 1'b1, 32'h12, 32'h00001234, 2'b01, 1'b0, r);
    n_cmp++; if (r.cyc !== 3 || r.nwe !== 1 || r.wdata !== 32'h12343344) begin
      n_bad++; $display("FAIL sh_upper: got cyc=%0d we=%0d data=%h expected cyc=3 we=1 data=12343344",
                        r.cyc, r.nwe, r.wdata);
    end
    idle();
    access(1'b1, 1'b0, 32'h12, 32'h0, 2'b01, 1'b0, r);
    n_cmp++; if (r.rd !== 32'h00001234) begin
      n_bad++; $display("FAIL lh_upper: got %h expected 00001234", r.rd);
    end
    idle();
    access(1'b0, 1'b1, 32'h10, 32'hFFFF8000, 2'b01, 1'b0, r);
    n_cmp++; if (r.wdata !== 32'h12348000) begin
      n_bad++; $display("FAIL sh_lower: got %h expected 12348000", r.wdata);
    end
    idle();
    access(1'b1, 1'b0, 32'h10, 32'h0, 2'b01, 1'b0, r);
    n_cmp++; if (r.rd !== 32'hFFFF8000) begin
      n_bad++; $display("FAIL lh_negative: got %h expected ffff8000", r.rd);
    end
    idle();
    access(1'b1, 1'b0, 32'h10, 32'h0, 2'b01, 1'b1, r);
    n_cmp++; if (r.rd !== 32'h00008000) begin
      n_bad++; $display("FAIL lhu: got %h expected 00008000", r.rd);
    end
    idle();
    access(1'b1, 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, r);
    n_cmp++; if (r.rd !== 32'h00000012) begin
      n_bad++; $display("FAIL lb_lane3: got %h expected 00000012", r.rd);
    end
    idle();
  endtask

  task automatic test_misalign();
    res_t r;
    logic [31:0] addrs [4] = '{32'h02, 32'h03, 32'h0, 32'h01};
    logic [1:0]  sizes [4] = '{2'b10, 2'b01, 2'b11, 2'b01};
    logic        wes   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      // Preceding load leaves nonzero data, so fromMem=0 here is meaningful.
      access(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, r);
      access(~wes[i], wes[i], addrs[i], 32'h5A5A5A5A, sizes[i], 1'b0, r);
      n_cmp++; if (r.cyc !== 2 || r.nre !== 0 || r.nwe !== 0 || r.mis !== 1'b1 || r.rd !== 32'h0 || r.leak) begin
        n_bad++; $display("FAIL misalign_%0d: got cyc=%0d re=%0d we=%0d mis=%b rd=%h expected cyc=2 re=0 we=0 mis=1 rd=0",
                          i, r.cyc, r.nre, r.nwe, r.mis, r.rd);
      end
      idle(); #1;
      n_cmp++; if ({misalign, stall, fromMem} !== 34'h0) begin
        n_bad++; $display("FAIL misalign_clear_%0d: got %h expected 0", i, {misalign, stall, fromMem});
      end
    end
    access(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, r);
    n_cmp++; if (r.rd !== 32'h12348000) begin
      n_bad++; $display("FAIL misalign_no_write: got %h expected 12348000", r.rd);
    end
    idle();
  endtask

  task automatic test_both_enables();
    res_t r;
    access(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 1'b1, r);
    n_cmp++; if (r.cyc !== 2 || r.nre !== 0 || r.nwe !== 1 || r.wdata !== 32'hCAFEF00D || r.rd !== 32'h0) begin
      n_bad++; $display("FAIL both_en_store: got cyc=%0d re=%0d we=%0d data=%h rd=%h expected cyc=2 re=0 we=1 data=cafef00d rd=0",
                        r.cyc, r.nre, r.nwe, r.wdata, r.rd);
    end
    idle();
    access(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, r);
    n_cmp++; if (r.rd !== 32'hCAFEF00D) begin
      n_bad++; $display("FAIL both_en_readback: got %h expected cafef00d", r.rd);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    res_t r;
    access(1'b0, 1'b1, 32'h24, 32'h13579BDF, 2'b10, 1'b0, r);
    n_cmp++; if (r.cyc !== 2 || r.waddr !== 10'd9) begin
      n_bad++; $display("FAIL b2b_sw: got cyc=%0d addr=%0d expected cyc=2 addr=9", r.cyc, r.waddr);
    end
    access(1'b1, 1'b0, 32'h24, 32'h0, 2'b10, 1'b1, r);
    n_cmp++; if (r.cyc !== 3 || r.rd !== 32'h13579BDF) begin
      n_bad++; $display("FAIL b2b_lw: got cyc=%0d rd=%h expected cyc=3 rd=13579bdf", r.cyc, r.rd);
    end
    access(1'b0, 1'b1, 32'h27, 32'hFFFFFF55, 2'b00, 1'b0, r);
    n_cmp++; if (r.cyc !== 3 || r.wdata !== 32'h55579BDF || r.clash) begin
      n_bad++; $display("FAIL b2b_sb: got cyc=%0d data=%h clash=%b expected cyc=3 data=55579bdf clash=0",
                        r.cyc, r.wdata, r.clash);
    end
    access(1'b1, 1'b0, 32'h24, 32'h0, 2'b00, 1'b0, r);
    n_cmp++; if (r.rd !== 32'hFFFFFFDF) begin
      n_bad++; $display("FAIL b2b_lb: got %h expected ffffffdf", r.rd);
    end
    access(1'b1, 1'b0, 32'h27, 32'h0, 2'b00, 1'b1, r);
    n_cmp++; if (r.rd !== 32'h00000055) begin
      n_bad++; $display("FAIL b2b_lbu: got %h expected 00000055", r.rd);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misalign();
    test_both_enables();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
